regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32I core family and its pipelined successors. It provides `NRD` combinational read ports and `NWR` synchronous write ports, with register 0 hardwired to zero. An integrated scoreboard holds one pending bit per register and a running count of pending registers, so a pipelined issue stage can detect RAW hazards. Optional write-to-read bypass is selected at compile time.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_if.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 82 ++++++++
 rtl/regfile_mp.sv | 82 ++++++++
 tb/tb_regfile_mp.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg                                                        |
// | Shared constants, address-width helper and typedefs for the        |
// | multi-port integer register file.                                  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Address width for a register count; never narrower than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  localparam int ADDR_W_DEFAULT = addr_width(NREGS_DEFAULT);

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0]   reg_data_t;

  // Hardwired-zero register index.
  localparam int unsigned REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_if                                                         |
// | Read, write, issue and flush signals of the register file.         |
// | master = pipeline side, slave = register file.                     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = addr_width(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_pending;
  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     flush;
  logic [AW:0]              pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_pending, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_pending, pend_cnt
  );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_scoreboard                                                 |
// | One pending bit per register plus a running pending count.         |
// | Priority per register: flush > issue > writeback > hold.           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NWR   = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   flush,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR-1:0][AW-1:0] wr_addr,
  output logic [NREGS-1:0]       pending,
  output logic [AW:0]            pend_cnt
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_nxt;
  logic [NREGS-1:0] wb_hit;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_nxt;
  logic [AW:0]      n_set;
  logic [AW:0]      n_clr;

  // Collapse all write ports into a per-register writeback mask.
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) wb_hit[wr_addr[p]] = 1'b1;
    end
  end

  // Next pending state; register 0 can never become pending.
  always_comb begin
    pend_nxt = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (r == 0)                                pend_nxt[r] = 1'b0;
      else if (flush)                            pend_nxt[r] = 1'b0;
      else if (iss_en && (iss_addr == AW'(r)))   pend_nxt[r] = 1'b1;
      else if (wb_hit[r])                        pend_nxt[r] = 1'b0;
      else                                       pend_nxt[r] = pend_q[r];
    end
  end

  // Count adjusts by the number of bits that rise and fall this cycle.
  always_comb begin
    n_set = '0;
    n_clr = '0;
    for (int r = 0; r < NREGS; r++) begin
      if (pend_nxt[r] && !pend_q[r]) n_set = n_set + CNT_ONE;
      if (!pend_nxt[r] && pend_q[r]) n_clr = n_clr + CNT_ONE;
    end
    cnt_nxt = flush ? '0 : (cnt_q + n_set - n_clr);
  end

  // Pending bits and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign pending  = pend_q;
  assign pend_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_mp                                                         |
// | Multi-port register file: NRD combinational reads, NWR synchronous |
// | writes (highest port wins), x0 hardwired to zero, RAW scoreboard.  |
// | Compile option: REGFILE_BYPASS_EN forwards same-cycle write data   |
// | to matching read ports.                                            |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;

  // Storage update; ascending port order makes the highest port win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p] != AW'(REG_ZERO)))
          regs[bus.wr_addr[p]] <= bus.wr_data[p];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .flush    (bus.flush),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .pending  (pending),
    .pend_cnt (bus.pend_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            pend;

    assign addr = bus.rd_addr[i];

    // Read mux with optional forwarding of the winning same-cycle write.
    always_comb begin
      data = regs[addr];
      pend = pending[addr];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && (addr != AW'(REG_ZERO))) begin
        for (int p = 0; p < NWR; p++) begin
          if (bus.wr_en[p] && (bus.wr_addr[p] == addr)) begin
            data = bus.wr_data[p];
            pend = (bus.iss_en && (bus.iss_addr == addr)) ? pending[addr] : 1'b0;
          end
        end
      end
`endif
    end

    assign bus.rd_data[i]    = data;
    assign bus.rd_pending[i] = pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_mp                                                      |
// | Scoreboard bench: stimulus pushes expected outputs into a queue,   |
// | a negedge monitor pops and compares. Array-based reference model.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  typedef struct packed {
    logic [NRD-1:0][XLEN-1:0] data;
    logic [NRD-1:0]           pend;
    logic [5:0]               cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mregs [NREGS];
  bit          mpend [NREGS];
  exp_t        q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Apply one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit rst, input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic ie, input logic [4:0] ia, input logic fl,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    exp_t        e;
    logic [4:0]  wa [NWR];
    logic [31:0] wd [NWR];
    logic [4:0]  ra [NRD];
    logic [5:0]  c;
    @(posedge clk);
    #1;
    cyc++;
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    ra[0] = ra0; ra[1] = ra1;
    rst_n           = ~rst;
    bus.wr_en       = we;
    bus.wr_addr[0]  = wa0;
    bus.wr_addr[1]  = wa1;
    bus.wr_data[0]  = wd0;
    bus.wr_data[1]  = wd1;
    bus.iss_en      = ie;
    bus.iss_addr    = ia;
    bus.flush       = fl;
    bus.rd_addr[0]  = ra0;
    bus.rd_addr[1]  = ra1;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mregs[r] = 32'h0;
        mpend[r] = 1'b0;
      end
    end
    for (int i = 0; i < NRD; i++) begin
      e.data[i] = mregs[ra[i]];
      e.pend[i] = mpend[ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (!rst && ra[i] != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && wa[p] == ra[i]) begin
            e.data[i] = wd[p];
            e.pend[i] = (ie && ia == ra[i]) ? mpend[ra[i]] : 1'b0;
          end
        end
      end
`endif
    end
    c = 6'd0;
    for (int r = 0; r < NREGS; r++) if (mpend[r]) c = c + 6'd1;
    e.cnt = c;
    q.push_back(e);
    if (!rst) begin
      for (int p = 0; p < NWR; p++)
        if (we[p] && wa[p] != 0) mregs[wa[p]] = wd[p];
      for (int r = 1; r < NREGS; r++) begin
        if (fl)                    mpend[r] = 1'b0;
        else if (ie && ia == r)    mpend[r] = 1'b1;
        else begin
          for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == r) mpend[r] = 1'b0;
        end
      end
    end
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        checks++;
        if (bus.rd_data[i] !== e.data[i]) begin
          errors++;
          $display("FAIL rd_data[%0d] cyc %0d: got %h expected %h", i, cyc, bus.rd_data[i], e.data[i]);
        end
        checks++;
        if (bus.rd_pending[i] !== e.pend[i]) begin
          errors++;
          $display("FAIL rd_pending[%0d] cyc %0d: got %b expected %b", i, cyc, bus.rd_pending[i], e.pend[i]);
        end
      end
      checks++;
      if (bus.pend_cnt !== e.cnt) begin
        errors++;
        $display("FAIL pend_cnt cyc %0d: got %0d expected %0d", cyc, bus.pend_cnt, e.cnt);
      end
    end
  end

  initial begin
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0; bus.rd_addr = '0;
    for (int r = 0; r < NREGS; r++) begin mregs[r] = 32'h0; mpend[r] = 1'b0; end

    // Reset state
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0);

    // Reset asserted mid-cycle after writing x5 and marking it pending
    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    step(0, 2'b00, 0, 0, 0, 0, 1, 5, 0, 5, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    step(1, 2'b01, 5, 32'h12345678, 0, 0, 1, 6, 0, 5, 6);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 6);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 6);

    // Same-address write conflict and writes to x0
    step(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 7, 0);
    step(0, 2'b01, 0, 32'hFFFF, 0, 0, 0, 0, 0, 7, 0);
    step(0, 2'b10, 0, 0, 0, 32'hFFFF, 1, 0, 0, 0, 7);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 7);

    // Scoreboard: issue x3, x4; write x3; same-cycle issue + write x4
    step(0, 2'b00, 0, 0, 0, 0, 1, 3, 0, 3, 4);
    step(0, 2'b00, 0, 0, 0, 0, 1, 4, 0, 3, 4);
    step(0, 2'b01, 3, 32'h33, 0, 0, 0, 0, 0, 3, 4);
    step(0, 2'b10, 0, 0, 4, 32'h44, 1, 4, 0, 3, 4);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 4);

    // Fill the scoreboard, then flush alongside an issue to x9
    for (int r = 1; r < NREGS; r++) step(0, 2'b00, 0, 0, 0, 0, 1, 5'(r), 0, 9, 31);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 31);
    step(0, 2'b00, 0, 0, 0, 0, 1, 9, 1, 9, 31);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 31);

    // Write-then-read of x10 in the same cycle, old value first
    step(0, 2'b01, 10, 32'h1234, 0, 0, 1, 10, 0, 10, 0);
    step(0, 2'b01, 10, 32'hCAFE, 0, 0, 0, 0, 0, 10, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    // Writeback racing a same-cycle issue, observed on the read port
    step(0, 2'b11, 12, 32'hA, 12, 32'hB, 1, 12, 0, 12, 10);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 10);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(0, 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 24) == 0),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
